// File: rtl/vga_sync_gen.sv
// 640x480@60 timing generator: pixel coordinates, sync pulses, blanking and frame strobes.
// Define VGA_SYNC_GAME_TICK_EN to build the frame counter that drives game_tick.
module vga_sync_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int TICK_FRAMES = 15
) (
    input  logic       clk25,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_end,
    output logic       game_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    if (TICK_FRAMES < 1) begin : g_bad_tick_frames
        $error("TICK_FRAMES must be >= 1");
    end

    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       frame_end_nxt;

    always_comb begin
        x_nxt = x + 10'd1;
        y_nxt = y;
        if (x == H_LAST) begin
            x_nxt = 10'd0;
            y_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
        end
        frame_end_nxt = (x_nxt == H_LAST) && (y_nxt == V_LAST);
    end

    // Decoding from the next-state counters keeps every strobe aligned with the x/y it describes.
    always_ff @(posedge clk25) begin
        if (rst) begin
            x         <= 10'd0;
            y         <= 10'd0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            video_on  <= 1'b1;
            frame_end <= 1'b0;
        end else begin
            x         <= x_nxt;
            y         <= y_nxt;
            hsync     <= ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync     <= ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
            video_on  <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
            frame_end <= frame_end_nxt;
        end
    end

`ifdef VGA_SYNC_GAME_TICK_EN
    localparam int CW = $clog2(TICK_FRAMES + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_FRAMES - 1);

    logic [CW-1:0] frame_cnt;

    // Tick fires on the same edge that raises frame_end for the TICK_FRAMES-th frame.
    always_ff @(posedge clk25) begin
        if (rst) begin
            frame_cnt <= '0;
            game_tick <= 1'b0;
        end else if (frame_end_nxt) begin
            if (frame_cnt == TICK_LAST) begin
                frame_cnt <= '0;
                game_tick <= 1'b1;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
                game_tick <= 1'b0;
            end
        end else begin
            game_tick <= 1'b0;
        end
    end
`else
    assign game_tick = 1'b0;
`endif

endmodule
